// File: rtl/mem_access_unit.sv
// MEM-stage access controller: turns byte addresses into word indices, extracts
// and extends sub-word loads, and runs a two-cycle read-modify-write for sb/sh.
module mem_access_unit #(
  parameter int WORD_ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        dm_read,
  output logic        dm_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t                 state_reg;
  logic [31:0]            merge_q;
  logic [WORD_ADDR_W-1:0] addr_reg;

  logic                   req;
  logic                   bad_align;
  logic                   sub_store;
  logic [WORD_ADDR_W-1:0] word_idx;
  logic [3:0]             byte_en;
  logic [31:0]            lane_data;
  logic [31:0]            merged;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [31:0]            load_val;
  logic                   unused_bits;

  // Address bits above the word index only matter for wrap-around, which is implicit
  assign unused_bits = ^addr[31:WORD_ADDR_W+2];

  assign req       = mem_read | mem_write;
  assign bad_align = (size == 2'b11) ||
                     (size == 2'b01 && addr[0]) ||
                     (size == 2'b10 && addr[1:0] != 2'b00);
  assign sub_store = mem_write && !bad_align && (size != 2'b10);
  assign word_idx  = addr[WORD_ADDR_W+1:2];

  // Byte-lane enables and replicated store data for the merge
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = {2{wdata[15:0]}};
    if (size == 2'b00) begin
      byte_en   = 4'b0001 << addr[1:0];
      lane_data = {4{wdata[7:0]}};
    end else begin
      byte_en   = addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Each lane takes the new byte when enabled, otherwise keeps the memory byte
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = byte_en[gi] ? lane_data[8*gi +: 8] : dm_rdata[8*gi +: 8];
    end
  endgenerate

  // Load extraction with sign or zero extension
  always_comb begin
    byte_sel = dm_rdata[7:0];
    case (addr[1:0])
      2'd0: byte_sel = dm_rdata[7:0];
      2'd1: byte_sel = dm_rdata[15:8];
      2'd2: byte_sel = dm_rdata[23:16];
      default: byte_sel = dm_rdata[31:24];
    endcase
    half_sel = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size)
      2'b00:   load_val = {{24{byte_sel[7] & ~load_uns}}, byte_sel};
      2'b01:   load_val = {{16{half_sel[15] & ~load_uns}}, half_sel};
      default: load_val = dm_rdata;
    endcase
  end

  // Output decode; reset forces every output low and drops a pending RMW write
  always_comb begin
    rdata    = 32'h0;
    stall    = 1'b0;
    misalign = 1'b0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    if (!rst) begin
      if (state_reg == RMW_WR) begin
        dm_write                   = 1'b1;
        dm_wdata                   = merge_q;
        dm_addr[WORD_ADDR_W-1:0]   = addr_reg;
      end else if (req) begin
        if (bad_align) begin
          misalign = 1'b1;
        end else if (mem_write) begin
          dm_addr[WORD_ADDR_W-1:0] = word_idx;
          if (size == 2'b10) begin
            dm_write = 1'b1;
            dm_wdata = wdata;
          end else begin
            dm_read = 1'b1;
            stall   = 1'b1;
          end
        end else begin
          dm_read                  = 1'b1;
          dm_addr[WORD_ADDR_W-1:0] = word_idx;
          rdata                    = load_val;
        end
      end
    end
  end

  // FSM: capture the merged word and its index, write it back the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      merge_q   <= 32'h0;
      addr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sub_store) begin
            merge_q   <= merged;
            addr_reg  <= word_idx;
            state_reg <= RMW_WR;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table-driven single-cycle accesses
// against a behavioural word memory, plus hand sequences for RMW and reset.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  logic        preload;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] e_rdata;
    logic [31:0] e_addr;
    logic        e_mis;
    logic        e_rdn;
    logic        e_wrn;
  } vec_t;

  vec_t        vecs [18];
  logic [31:0] sb_q [$];

  mem_access_unit #(.WORD_ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .size     (size),
    .load_uns (load_uns),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .misalign (misalign),
    .dm_read  (dm_read),
    .dm_write (dm_write),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on rising edge
  assign dm_rdata = mem[dm_addr[7:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h8899AABB;
      mem[3] <= 32'h11223344;
    end else if (dm_write) begin
      mem[dm_addr[7:0]] <= dm_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    mem_read  = rd;
    mem_write = wr;
    size      = sz;
    load_uns  = u;
    addr      = a;
    wdata     = wd;
  endtask

  initial begin
    //           rd wr sz     uns addr        wdata         e_rdata       e_addr    mis rd wr
    vecs[0]  = '{1, 0, 2'b00, 0, 32'h7,     32'h0,        32'hFFFFFF88, 32'h1,    0,  1, 0};
    vecs[1]  = '{1, 0, 2'b00, 1, 32'h7,     32'h0,        32'h00000088, 32'h1,    0,  1, 0};
    vecs[2]  = '{1, 0, 2'b01, 0, 32'h4,     32'h0,        32'hFFFFAABB, 32'h1,    0,  1, 0};
    vecs[3]  = '{1, 0, 2'b01, 1, 32'h6,     32'h0,        32'h00008899, 32'h1,    0,  1, 0};
    vecs[4]  = '{1, 0, 2'b00, 0, 32'h4,     32'h0,        32'hFFFFFFBB, 32'h1,    0,  1, 0};
    vecs[5]  = '{1, 0, 2'b00, 1, 32'h5,     32'h0,        32'h000000AA, 32'h1,    0,  1, 0};
    vecs[6]  = '{1, 0, 2'b10, 0, 32'h4,     32'h0,        32'h8899AABB, 32'h1,    0,  1, 0};
    vecs[7]  = '{1, 0, 2'b10, 0, 32'h404,   32'h0,        32'h8899AABB, 32'h1,    0,  1, 0};
    vecs[8]  = '{1, 0, 2'b01, 0, 32'h3,     32'h0,        32'h0,        32'h0,    1,  0, 0};
    vecs[9]  = '{1, 0, 2'b10, 0, 32'h2,     32'h0,        32'h0,        32'h0,    1,  0, 0};
    vecs[10] = '{1, 0, 2'b11, 0, 32'h4,     32'h0,        32'h0,        32'h0,    1,  0, 0};
    vecs[11] = '{0, 0, 2'b10, 0, 32'h4,     32'h0,        32'h0,        32'h0,    0,  0, 0};
    vecs[12] = '{0, 1, 2'b10, 0, 32'h8,     32'hDEADBEEF, 32'h0,        32'h2,    0,  0, 1};
    vecs[13] = '{1, 0, 2'b10, 0, 32'h8,     32'h0,        32'hDEADBEEF, 32'h2,    0,  1, 0};
    vecs[14] = '{1, 1, 2'b10, 0, 32'h10,    32'h01020304, 32'h0,        32'h4,    0,  0, 1};
    vecs[15] = '{1, 0, 2'b10, 0, 32'h10,    32'h0,        32'h01020304, 32'h4,    0,  1, 0};
    vecs[16] = '{0, 1, 2'b01, 0, 32'h1,     32'h0000FFFF, 32'h0,        32'h0,    1,  0, 0};
    vecs[17] = '{0, 1, 2'b11, 0, 32'h0,     32'h000000FF, 32'h0,        32'h0,    1,  0, 0};

    preload = 1'b1;
    rst     = 1'b1;
    drive(1, 0, 2'b11, 0, 32'h4, 32'h0);

    // Reset: misaligned load request must not show through
    @(negedge clk);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_dm_read", {31'h0, dm_read}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    $display("txn reset misaligned load: misalign=%0b dm_read=%0b", misalign, dm_read);
    @(posedge clk); #1;
    drive(0, 1, 2'b10, 0, 32'h8, 32'h12345678);
    @(negedge clk);
    chk("rst_dm_write", {31'h0, dm_write}, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    $display("txn reset word store: dm_write=%0b", dm_write);
    @(posedge clk); #1;
    rst     = 1'b0;
    preload = 1'b0;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);

    // Table-driven single-cycle accesses with a scoreboard of expected rdata
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd);
      sb_q.push_back(vecs[i].e_rdata);
      @(negedge clk);
      chk($sformatf("v%0d_rdata", i), rdata, sb_q.pop_front());
      chk($sformatf("v%0d_misalign", i), {31'h0, misalign}, {31'h0, vecs[i].e_mis});
      chk($sformatf("v%0d_dm_read", i), {31'h0, dm_read}, {31'h0, vecs[i].e_rdn});
      chk($sformatf("v%0d_dm_write", i), {31'h0, dm_write}, {31'h0, vecs[i].e_wrn});
      chk($sformatf("v%0d_stall", i), {31'h0, stall}, 32'h0);
      if (vecs[i].e_rdn || vecs[i].e_wrn)
        chk($sformatf("v%0d_dm_addr", i), dm_addr, vecs[i].e_addr);
      if (vecs[i].e_wrn)
        chk($sformatf("v%0d_dm_wdata", i), dm_wdata, vecs[i].wd);
      $display("txn v%0d rd=%0b wr=%0b size=%0d addr=%08h rdata=%08h misalign=%0b",
               i, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].a, rdata, misalign);
    end
    @(posedge clk); #1;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("mem2_sw", mem[2], 32'hDEADBEEF);
    chk("mem4_rw_both", mem[4], 32'h01020304);
    chk("mem0_untouched", mem[0], 32'h0);
    chk("mem1_untouched", mem[1], 32'h8899AABB);
    chk("queue_empty", sb_q.size(), 32'h0);

    // sb 0xA5 at 0xD: one stall cycle, then the merged write
    @(posedge clk); #1;
    drive(0, 1, 2'b00, 0, 32'hD, 32'h000000A5);
    @(negedge clk);
    chk("sb_stall", {31'h0, stall}, 32'h1);
    chk("sb_dm_read", {31'h0, dm_read}, 32'h1);
    chk("sb_dm_write0", {31'h0, dm_write}, 32'h0);
    chk("sb_dm_addr", dm_addr, 32'h3);
    @(negedge clk);
    chk("sb_wr_stall", {31'h0, stall}, 32'h0);
    chk("sb_wr_dm_write", {31'h0, dm_write}, 32'h1);
    chk("sb_wr_dm_read", {31'h0, dm_read}, 32'h0);
    chk("sb_wr_dm_wdata", dm_wdata, 32'h1122A544);
    chk("sb_wr_dm_addr", dm_addr, 32'h3);
    @(posedge clk); #1;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("sb_mem3", mem[3], 32'h1122A544);
    $display("txn sb addr=0000000d mem3=%08h", mem[3]);

    // sh 0xCAFE at 0x6, then back-to-back lw from 0x4
    @(posedge clk); #1;
    drive(0, 1, 2'b01, 0, 32'h6, 32'h0000CAFE);
    @(negedge clk);
    chk("sh_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    chk("sh_wr_dm_wdata", dm_wdata, 32'hCAFEAABB);
    @(posedge clk); #1;
    drive(1, 0, 2'b10, 0, 32'h4, 32'h0);
    @(negedge clk);
    chk("sh_lw_rdata", rdata, 32'hCAFEAABB);
    chk("sh_lw_stall", {31'h0, stall}, 32'h0);
    chk("sh_mem1", mem[1], 32'hCAFEAABB);
    $display("txn sh addr=00000006 then lw rdata=%08h", rdata);

    // sb at 0x5 with reset asserted during the write-back cycle
    @(posedge clk); #1;
    drive(0, 1, 2'b00, 0, 32'h5, 32'h00000077);
    @(negedge clk);
    chk("rstrmw_stall", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstrmw_dm_write", {31'h0, dm_write}, 32'h0);
    chk("rstrmw_stall0", {31'h0, stall}, 32'h0);
    chk("rstrmw_dm_read", {31'h0, dm_read}, 32'h0);
    chk("rstrmw_dm_wdata", dm_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 0, 2'b10, 0, 32'h4, 32'h0);
    @(negedge clk);
    chk("rstrmw_idle_write", {31'h0, dm_write}, 32'h0);
    chk("rstrmw_idle_read", {31'h0, dm_read}, 32'h1);
    chk("rstrmw_lw_rdata", rdata, 32'hCAFEAABB);
    chk("rstrmw_mem1", mem[1], 32'hCAFEAABB);
    $display("txn sb aborted by reset: mem1=%08h", mem[1]);

    @(posedge clk); #1;
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
